retire_trace_buf: RTL
=====================

// Module: retire_trace_buf
// PURPOSE
//  Synthesizable, parametrised successor of the per-cycle CPU bench monitor. Captures one record per
//  retired instruction (PC, inst, rd, rf_we, wdata, trap flag) from the WB stage of the pipelined RV32i core.
//  Records go into a circular buffer with wrap, fill-stop and trigger/post-trigger modes.
//  Sits beside wb_stage/csr/clint; a debug host or bench drains it over a valid/ready read port.
// PARAMETERS
//  DEPTH    16   record slots, power of 2, >=2
//  PC_W     32   PC / instruction / wdata width
//  RD_W     5    destination register index width
//  POST_W   8    width of the post-trigger record count
//  REC_W    3*PC_W+RD_W+2   packed record width, derived, never overridden
// PORTS
//  clk          in   1       core clock
//  rst_n        in   1       asynchronous active-low reset
//  arm          in   1       pulse: clear buffer, latch mode/post_cnt, start capture
//  disarm       in   1       pulse: stop capture -> IDLE, contents retained
//  mode         in   2       0 WRAP, 1 FILL, 2 TRIGGER, 3 reserved (= WRAP); sampled on arm
//  post_cnt     in   POST_W  records captured after trigger record; sampled on arm
//  trig_pc_en   in   1       enable PC-match trigger
//  trig_pc      in   PC_W    PC compare value
//  trig_on_trap in   1       enable trap-retire trigger
//  ret_valid    in   1       one instruction retires this cycle
//  ret_pc       in   PC_W    retiring PC
//  ret_inst     in   PC_W    retiring instruction word
//  ret_rd       in   RD_W    destination register
//  ret_rf_we    in   1       register-file write enable
//  ret_wdata    in   PC_W    write-back data
//  ret_trap     in   1       retirement caused trap entry
//  rd_valid     out  1       record available at rd_data
//  rd_ready     in   1       consumer pops when rd_valid & rd_ready
//  rd_data      out  REC_W   {pc,inst,wdata,rd,rf_we,trap} MSB->LSB, oldest record
//  count        out  $clog2(DEPTH)+1  stored records, 0..DEPTH
//  state        out  2       0 IDLE, 1 ARMED, 2 POST, 3 FROZEN
//  overflow     out  1       sticky: a record was overwritten since last arm
//  triggered    out  1       sticky: trigger hit since last arm
// BEHAVIOUR
//  Reset: state=IDLE, wr_ptr=rd_ptr=0, count=0, overflow=0, triggered=0, rd_valid=0; RAM not cleared.
//  hit = ret_valid & ((trig_pc_en & ret_pc==trig_pc) | (trig_on_trap & ret_trap)).
//  capture = ret_valid & state in {ARMED,POST}. Record written at the edge, visible in count next cycle.
//  IDLE: no capture. arm -> ARMED (ptrs, count, overflow, triggered cleared same edge).
//  ARMED, WRAP/TRIGGER: capture; full+capture -> overwrite oldest, rd_ptr++, count holds DEPTH, overflow=1.
//  ARMED, FILL: capture; capture making count==DEPTH -> FROZEN; never overwrites, overflow stays 0.
//  ARMED, TRIGGER: hit record is captured, triggered=1; post_cnt_q==0 -> FROZEN, else -> POST, rem=post_cnt_q.
//  ARMED, WRAP/FILL: hit sets triggered only, no state change.
//  POST: capture as WRAP, rem-- per capture; capture with rem==1 -> FROZEN. Further hits ignored.
//  FROZEN: no capture. arm -> ARMED; disarm -> IDLE.
//  disarm wins over arm in the same cycle. disarm from any state -> IDLE.
//  Read port: rd_valid = (count!=0) & state in {IDLE,FROZEN}; rd_data = mem[rd_ptr] combinational.
//  Pop: rd_ptr++ (wraps mod DEPTH), count--. No pops while ARMED/POST.
//  Pointers wrap mod DEPTH. count saturates at DEPTH.
//  Async reset mid-capture discards all state; reads after reset see count=0.
// STRUCTURE
//  trace_defs.vh: state/mode encodings and record field offsets, shared with cpu_tb for decoding.
//  Sub-module trace_ram: DEPTH x REC_W, 1 sync write port, 1 async read port.
//  Top holds FSM, pointers, count, rem counter and sticky flags.
// TESTING
//  1 WRAP, DEPTH=16, 20 retires PC 0x00..0x4C -> count=16, overflow=1, drain gives PC 0x10..0x4C in order.
//  2 FILL, 20 retires -> FROZEN after 16th, count=16, overflow=0, first pop PC=0x00, last pop PC=0x3C.
//  3 TRIGGER, trig_pc=0x20, post_cnt=3, PCs 0x00.. step 4 -> FROZEN after PC 0x2C; last 4 drained 0x20..0x2C.
//  4 TRIGGER, trig_on_trap, ecall retire trap=1, post_cnt=0 -> FROZEN same edge, newest record trap=1.
//  5 arm+disarm same cycle -> IDLE. rst_n low during POST -> state=0, count=0, rd_valid=0.
//  6 FROZEN, rd_ready toggled 1/0 -> one pop per handshake, count reaches 0, then rd_valid=0.

Source files
------------

// File: rtl/retire_trace_buf_pkg.sv
// Shared encodings for the retire trace buffer: FSM states, capture modes and
// the packed record width helper used by both the top and its consumers.
package retire_trace_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_POST   = 2'd2,
    ST_FROZEN = 2'd3
  } trace_state_e;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_FILL    = 2'd1,
    MODE_TRIGGER = 2'd2,
    MODE_RSVD    = 2'd3
  } trace_mode_e;

  // Record layout MSB->LSB: {pc, inst, wdata, rd, rf_we, trap}
  function automatic int rec_width(input int pc_w, input int rd_w);
    return 3 * pc_w + rd_w + 2;
  endfunction

endpackage

// File: rtl/retire_trace_buf_ram.sv
// Record storage: DEPTH x WIDTH, one synchronous write port, one asynchronous
// read port. Contents are intentionally not reset.
module retire_trace_buf_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 103
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/retire_trace_buf.sv
// Retirement trace buffer: captures one record per retired instruction into a
// circular buffer with wrap, fill-stop and trigger/post-trigger modes.
module retire_trace_buf
  import retire_trace_buf_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int PC_W   = 32,
  parameter int RD_W   = 5,
  parameter int POST_W = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               arm,
  input  logic                               disarm,
  input  logic [1:0]                         mode,
  input  logic [POST_W-1:0]                  post_cnt,
  input  logic                               trig_pc_en,
  input  logic [PC_W-1:0]                    trig_pc,
  input  logic                               trig_on_trap,
  input  logic                               ret_valid,
  input  logic [PC_W-1:0]                    ret_pc,
  input  logic [PC_W-1:0]                    ret_inst,
  input  logic [RD_W-1:0]                    ret_rd,
  input  logic                               ret_rf_we,
  input  logic [PC_W-1:0]                    ret_wdata,
  input  logic                               ret_trap,
  output logic                               rd_valid,
  input  logic                               rd_ready,
  output logic [rec_width(PC_W, RD_W)-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]             count,
  output logic [1:0]                         state,
  output logic                               overflow,
  output logic                               triggered
);

  localparam int REC_W = rec_width(PC_W, RD_W);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [CW-1:0] FULL_M1 = CW'(DEPTH - 1);

  trace_state_e      state_q, state_d;
  trace_mode_e       mode_q, mode_d;
  logic [POST_W-1:0] post_q, post_d;
  logic [POST_W-1:0] rem_q, rem_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              triggered_q, triggered_d;

  logic              hit;
  logic              capture;
  logic              pop;
  logic              ram_we;
  logic [REC_W-1:0]  wr_rec;

  assign hit      = ret_valid & ((trig_pc_en & (ret_pc == trig_pc)) | (trig_on_trap & ret_trap));
  assign capture  = ret_valid & ((state_q == ST_ARMED) | (state_q == ST_POST));
  assign rd_valid = (count_q != '0) & ((state_q == ST_IDLE) | (state_q == ST_FROZEN));
  assign pop      = rd_valid & rd_ready;
  assign wr_rec   = {ret_pc, ret_inst, ret_wdata, ret_rd, ret_rf_we, ret_trap};

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    post_d      = post_q;
    rem_d       = rem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    triggered_d = triggered_q;
    ram_we      = 1'b0;

    // Pops and captures never coexist: pops need IDLE/FROZEN, captures ARMED/POST.
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      count_d  = count_q - CW'(1);
    end

    if (disarm) begin
      state_d = ST_IDLE;
    end else if (arm) begin
      state_d     = ST_ARMED;
      mode_d      = (mode == MODE_RSVD) ? MODE_WRAP : trace_mode_e'(mode);
      post_d      = post_cnt;
      rem_d       = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      triggered_d = 1'b0;
    end else if (capture) begin
      ram_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (count_q == FULL) begin
        rd_ptr_d   = rd_ptr_q + AW'(1);
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
      if (hit) triggered_d = 1'b1;

      if (state_q == ST_ARMED) begin
        if (mode_q == MODE_FILL && count_q == FULL_M1) begin
          state_d = ST_FROZEN;
        end else if (mode_q == MODE_TRIGGER && hit) begin
          if (post_q == '0) begin
            state_d = ST_FROZEN;
          end else begin
            state_d = ST_POST;
            rem_d   = post_q;
          end
        end
      end else begin
        rem_d = rem_q - POST_W'(1);
        if (rem_q == POST_W'(1)) state_d = ST_FROZEN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_WRAP;
      post_q      <= '0;
      rem_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      triggered_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      post_q      <= post_d;
      rem_q       <= rem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      triggered_q <= triggered_d;
    end
  end

  retire_trace_buf_ram #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (wr_rec),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign count     = count_q;
  assign state     = state_q;
  assign overflow  = overflow_q;
  assign triggered = triggered_q;

endmodule
